// File: rtl/vector_sweep_checker.sv
// rtl/vector_sweep_checker.sv - exhaustive stimulus sweeper and zero-response counter
//
// Purpose:
//   Drives every IN_W-bit vector into a combinational DUT, holds each vector
//   SETTLE cycles, samples the DUT response in the last cycle of each window,
//   counts the vectors whose response is all zero and flags a fully-zero sweep.
//
// Optional feature (macro FIRST_NZ_CAPTURE_EN):
//   Captures the first vector of a sweep whose response is nonzero and exposes
//   first_nz_valid / first_nz_vec. Without the macro those ports do not exist.
//
// Ports:
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous active-high reset
//   start          in   1      begin a sweep; accepted only while busy==0
//   dut_out        in   OUT_W  DUT response to dut_in
//   dut_in         out  IN_W   registered stimulus vector
//   busy           out  1      sweep in progress
//   done           out  1      one-cycle pulse when a sweep completes
//   zero_cnt       out  CNT_W  vectors with dut_out==0; held until next start
//   all_zero       out  1      zero_cnt == 2**IN_W; valid from done until next start
//   first_nz_valid out  1      (FIRST_NZ_CAPTURE_EN) a nonzero response was seen
//   first_nz_vec   out  IN_W   (FIRST_NZ_CAPTURE_EN) first vector with nonzero response

module vector_sweep_checker #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 20,
  parameter int CNT_W  = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] zero_cnt,
  output logic             all_zero
`ifdef FIRST_NZ_CAPTURE_EN
  ,
  output logic             first_nz_valid,
  output logic [IN_W-1:0]  first_nz_vec
`endif
);

  // A one-bit counter is kept even when SETTLE==1; it then never leaves zero
  // and every RUN cycle is a sample cycle.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IN_W-1:0]  r_dut_in;
  logic [SET_W-1:0] r_settle;
  logic [CNT_W-1:0] r_zero_cnt;
  logic             r_all_zero;

  logic             w_start_acc;
  logic             w_sample;
  logic             w_last_vec;
  logic             w_out_zero;
  logic [CNT_W-1:0] w_zero_cnt_nxt;
  logic [CNT_W-1:0] w_full_cnt;

  // busy==0 in both IDLE and DONE, so a start in the DONE cycle chains sweeps.
  assign w_start_acc    = start && (r_state != S_RUN);
  assign w_sample       = (r_state == S_RUN) && (r_settle == SET_W'(SETTLE - 1));
  assign w_last_vec     = (r_dut_in == {IN_W{1'b1}});
  assign w_out_zero     = (dut_out == '0);
  assign w_zero_cnt_nxt = r_zero_cnt + CNT_W'(w_out_zero);
  assign w_full_cnt     = CNT_W'(2 ** IN_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_sample && w_last_vec) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dut_in   <= '0;
      r_settle   <= '0;
      r_zero_cnt <= '0;
      r_all_zero <= 1'b0;
    end else if (w_start_acc) begin
      r_dut_in   <= '0;
      r_settle   <= '0;
      r_zero_cnt <= '0;
      r_all_zero <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_sample) begin
        r_zero_cnt <= w_zero_cnt_nxt;
        r_settle   <= '0;
        if (w_last_vec) begin
          // Final sample: flag is computed from the count including this vector.
          r_dut_in   <= '0;
          r_all_zero <= (w_zero_cnt_nxt == w_full_cnt);
        end else begin
          r_dut_in <= r_dut_in + IN_W'(1);
        end
      end else begin
        r_settle <= r_settle + SET_W'(1);
      end
    end
  end

`ifdef FIRST_NZ_CAPTURE_EN
  logic            r_nz_valid;
  logic [IN_W-1:0] r_nz_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nz_valid <= 1'b0;
      r_nz_vec   <= '0;
    end else if (w_start_acc) begin
      r_nz_valid <= 1'b0;
      r_nz_vec   <= '0;
    end else if (w_sample && !w_out_zero && !r_nz_valid) begin
      r_nz_valid <= 1'b1;
      r_nz_vec   <= r_dut_in;
    end
  end

  assign first_nz_valid = r_nz_valid;
  assign first_nz_vec   = r_nz_vec;
`endif

  assign dut_in   = r_dut_in;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign zero_cnt = r_zero_cnt;
  assign all_zero = r_all_zero;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// tb/tb_vector_sweep_checker.sv - directed self-checking bench for vector_sweep_checker

module tb_vector_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dut_out;
  logic [2:0] dut_in;
  logic       busy;
  logic       done;
  logic [3:0] zero_cnt;
  logic       all_zero;
`ifdef FIRST_NZ_CAPTURE_EN
  logic       first_nz_valid;
  logic [2:0] first_nz_vec;
`endif

  logic       start6;
  logic [1:0] dut_out6;
  logic [3:0] dut_in6;
  logic       busy6;
  logic       done6;
  logic [4:0] zero_cnt6;
  logic       all_zero6;
`ifdef FIRST_NZ_CAPTURE_EN
  logic       first_nz_valid6;
  logic [3:0] first_nz_vec6;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;

  always #5 clk = ~clk;

  vector_sweep_checker #(.IN_W(3), .OUT_W(2), .SETTLE(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out), .dut_in(dut_in),
    .busy(busy), .done(done), .zero_cnt(zero_cnt), .all_zero(all_zero)
`ifdef FIRST_NZ_CAPTURE_EN
    , .first_nz_valid(first_nz_valid), .first_nz_vec(first_nz_vec)
`endif
  );

  vector_sweep_checker #(.IN_W(4), .OUT_W(2), .SETTLE(1), .CNT_W(5)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .dut_out(dut_out6), .dut_in(dut_in6),
    .busy(busy6), .done(done6), .zero_cnt(zero_cnt6), .all_zero(all_zero6)
`ifdef FIRST_NZ_CAPTURE_EN
    , .first_nz_valid(first_nz_valid6), .first_nz_vec(first_nz_vec6)
`endif
  );

  // Modelled combinational DUT: dut_out = {y, x}, a=bit0, b=bit1, c=bit2.
  always_comb begin
    dut_out = 2'b00;
    case (mode)
      1: dut_out = {1'b0, &dut_in};
      2: dut_out = {dut_in[0] ^ dut_in[1], |dut_in};
      default: dut_out = 2'b00;
    endcase
  end

  assign dut_out6 = 2'b00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic accept();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered at cycle 1 of a sweep (the cycle after the accepting edge).
  task automatic run_sweep(input int exp_zc, input logic exp_az, input logic exp_nzv,
                           input int exp_nz_vec, input int re1, input int re2,
                           input bit start_at_done);
    for (int c = 1; c <= 33; c++) begin
      if (c < 33) begin
        check("busy_run", busy, 1);
        check("done_run", done, 0);
        check("dut_in_run", dut_in, (c - 1) / 4);
      end else begin
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("dut_in_done", dut_in, 0);
        check("zero_cnt_done", zero_cnt, exp_zc);
        check("all_zero_done", all_zero, exp_az);
`ifdef FIRST_NZ_CAPTURE_EN
        check("first_nz_valid", first_nz_valid, exp_nzv);
        check("first_nz_vec", first_nz_vec, exp_nz_vec);
`endif
      end
      start = (c == re1) || (c == re2) || ((c == 33) && start_at_done);
      tick();
    end
    start = 1'b0;
    if (!start_at_done) begin
      check("done_one_cycle", done, 0);
      check("busy_after", busy, 0);
      check("zero_cnt_held", zero_cnt, exp_zc);
      check("all_zero_held", all_zero, exp_az);
    end
  endtask

  initial begin
    int n_done;
    rst    = 1'b1;
    start  = 1'b0;
    start6 = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_zero_cnt", zero_cnt, 0);
    check("rst_all_zero", all_zero, 0);
`ifdef FIRST_NZ_CAPTURE_EN
    check("rst_nz_valid", first_nz_valid, 0);
    check("rst_nz_vec", first_nz_vec, 0);
`endif
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // 1: all-zero responses
    mode = 0;
    accept();
    run_sweep(8, 1'b1, 1'b0, 0, 0, 0, 1'b0);

    // 2: x = a&b&c
    mode = 1;
    accept();
    check("clear_all_zero", all_zero, 0);
    check("clear_zero_cnt", zero_cnt, 0);
    run_sweep(7, 1'b0, 1'b1, 7, 0, 0, 1'b0);

    // 3: x = a|b|c, y = a^b
    mode = 2;
    accept();
    run_sweep(1, 1'b0, 1'b1, 1, 0, 0, 1'b0);

    // 4: reset in the middle of a sweep
    mode = 0;
    accept();
    for (int c = 1; c < 10; c++) tick();
    check("mid_zero_cnt", zero_cnt, 2);
    check("mid_dut_in", dut_in, 2);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dut_in", dut_in, 0);
    check("abort_zero_cnt", zero_cnt, 0);
    check("abort_done", done, 0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) n_done++;
      tick();
    end
    check("abort_no_done", n_done, 0);

    // 5: starts while busy ignored; start in DONE chains a new sweep
    mode = 0;
    accept();
    run_sweep(8, 1'b1, 1'b0, 0, 5, 20, 1'b1);
    mode = 1;
    check("chain_busy", busy, 1);
    check("chain_dut_in", dut_in, 0);
    check("chain_zero_cnt", zero_cnt, 0);
    check("chain_all_zero", all_zero, 0);
`ifdef FIRST_NZ_CAPTURE_EN
    check("chain_nz_valid", first_nz_valid, 0);
`endif
    run_sweep(7, 1'b0, 1'b1, 7, 0, 0, 1'b0);

    // 6: SETTLE=1, IN_W=4 instance
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c < 17) begin
        check("s1_busy", busy6, 1);
        check("s1_done", done6, 0);
        check("s1_dut_in", dut_in6, c - 1);
      end else begin
        check("s1_done_pulse", done6, 1);
        check("s1_zero_cnt", zero_cnt6, 16);
        check("s1_all_zero", all_zero6, 1);
      end
      tick();
    end
    check("s1_done_clear", done6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
